// File: rtl/dgt_pack.sv
// Serial BCD digit packer: accumulates MSD-first digits into a signed result
// and holds it with a valid/ready handshake until the consumer takes it.
module dgt_pack #(
    parameter int MAX_DIGITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_digit,
    input  logic        in_neg,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] out_value,
    output logic        out_err,
    output logic        busy
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [9:0]      r_acc;
    logic [9:0]      w_acc_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_err;
    logic            w_err_nxt;
    logic            r_neg;
    logic            w_neg_nxt;
    logic [9:0]      w_base;
    logic [13:0]     w_sum;
    logic            w_bad_digit;

    logic            r_in_ready;
    logic            r_out_valid;
    logic [10:0]     r_out_value;
    logic            r_out_err;
    logic            r_busy;

    // Errored results report the saturated magnitude; negative zero folds to 0.
    function automatic logic [10:0] f_result(input logic [9:0] acc,
                                             input logic       neg,
                                             input logic       err);
        if (err) begin
            return 11'd999;
        end else if (neg) begin
            return 11'd0 - {1'b0, acc};
        end else begin
            return {1'b0, acc};
        end
    endfunction

    assign w_bad_digit = (in_digit > 4'd9);
    assign w_base      = (r_state == S_IDLE) ? 10'd0 : r_acc;
    assign w_sum       = ({4'd0, w_base} * 14'd10)
                       + (w_bad_digit ? 14'd0 : {10'd0, in_digit});

    // Next-state and datapath update; clear overrides every other action.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_neg_nxt   = r_neg;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_acc_nxt   = 10'd0;
            w_cnt_nxt   = {CW{1'b0}};
            w_err_nxt   = 1'b0;
            w_neg_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (in_valid) begin
                        if (r_state == S_IDLE) begin
                            w_neg_nxt = in_neg;
                        end else begin
                            w_neg_nxt = r_neg;
                        end
                        if (r_cnt == CW'(MAX_DIGITS)) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                            if (w_bad_digit || (w_sum > 14'd999)) begin
                                w_err_nxt = 1'b1;
                            end else begin
                                w_err_nxt = r_err;
                            end
                            if (w_sum > 14'd999) begin
                                w_acc_nxt = r_acc;
                            end else begin
                                w_acc_nxt = w_sum[9:0];
                            end
                        end
                        w_state_nxt = in_last ? S_DONE : S_ACCUM;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        w_state_nxt = S_IDLE;
                        w_acc_nxt   = 10'd0;
                        w_cnt_nxt   = {CW{1'b0}};
                        w_err_nxt   = 1'b0;
                        w_neg_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_acc_nxt   = 10'd0;
                    w_cnt_nxt   = {CW{1'b0}};
                    w_err_nxt   = 1'b0;
                    w_neg_nxt   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= 10'd0;
            r_cnt   <= {CW{1'b0}};
            r_err   <= 1'b0;
            r_neg   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_neg   <= w_neg_nxt;
        end
    end

    // Outputs are registered from the next-state view so they track the state flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_value <= 11'd0;
            r_out_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt != S_DONE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_out_value <= (w_state_nxt == S_DONE) ? f_result(w_acc_nxt, w_neg_nxt, w_err_nxt) : 11'd0;
            r_out_err   <= (w_state_nxt == S_DONE) ? w_err_nxt : 1'b0;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_value = r_out_value;
    assign out_err   = r_out_err;
    assign busy      = r_busy;

endmodule
